// File: rtl/disp_msg_seq.sv
// disp_msg_seq: display message sequencer for a calculator front end.
// Chooses what the display shows (number, "OP", "VAL" or "ERR"), latches
// accepted results as sign/magnitude, and holds an error message for
// HOLD_CYCLES clocks before the prompt is restored.
// Optional feature macro: DISP_SATURATE_EN -- when defined, results whose
// magnitude exceeds 255 are shown saturated at 255 instead of raising ERR.
module disp_msg_seq #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic        res_err,
  input  logic [1:0]  res_dot,
  input  logic        op_req,
  input  logic        val_req,
  output logic        res_ready,
  output logic [1:0]  msg,
  output logic [7:0]  bin,
  output logic        sgn,
  output logic [1:0]  dot,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    PROMPT_OP,
    PROMPT_VAL,
    SHOW_RES,
    SHOW_ERR
  } state_t;

  localparam logic [25:0] HOLD_LOAD = 26'(HOLD_CYCLES - 1);

  state_t      r_state, w_state;
  logic [25:0] r_cnt, w_cnt;
  logic [7:0]  r_bin, w_bin;
  logic        r_sgn, w_sgn;
  logic [1:0]  r_dot, w_dot;
  logic        r_have, w_have;
  logic        r_ready, w_ready;
  logic [1:0]  r_msg, w_msg;
  logic        r_busy, w_busy;

  logic        w_accept;
  logic [16:0] w_ext;
  logic [16:0] w_mag;
  logic        w_ovf;
  logic        w_to_err;

  // Result magnitude: 17 bits so that -32768 becomes +32768 and overflows.
  always_comb begin
    w_accept = res_valid & r_ready;
    w_ext    = {res_data[15], res_data};
    w_mag    = res_data[15] ? (~w_ext + 17'd1) : w_ext;
    w_ovf    = |w_mag[16:8];
`ifdef DISP_SATURATE_EN
    w_to_err = res_err;
`else
    w_to_err = res_err | w_ovf;
`endif
  end

  // Next-state, held-value and registered-output computation.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bin   = r_bin;
    w_sgn   = r_sgn;
    w_dot   = r_dot;
    w_have  = r_have;
    unique case (r_state)
      SHOW_ERR: begin
        if (r_cnt == '0) begin
          if (op_req)       w_state = PROMPT_OP;
          else if (val_req) w_state = PROMPT_VAL;
          else              w_state = IDLE;
          w_bin  = '0;
          w_sgn  = 1'b0;
          w_dot  = '0;
          w_have = 1'b0;
        end else begin
          w_cnt = r_cnt - 26'd1;
        end
      end
      default: begin
        if (w_accept) begin
          if (w_to_err) begin
            w_state = SHOW_ERR;
            w_cnt   = HOLD_LOAD;
          end else begin
            w_state = SHOW_RES;
            w_bin   = w_ovf ? 8'hFF : w_mag[7:0];
            w_sgn   = res_data[15];
            w_dot   = res_dot;
            w_have  = 1'b1;
          end
        end else if (op_req) begin
          w_state = PROMPT_OP;
        end else if (val_req) begin
          w_state = PROMPT_VAL;
        end else if (r_state == PROMPT_OP || r_state == PROMPT_VAL) begin
          w_state = r_have ? SHOW_RES : IDLE;
        end
      end
    endcase

    unique case (w_state)
      PROMPT_OP:  w_msg = 2'b01;
      PROMPT_VAL: w_msg = 2'b10;
      SHOW_ERR:   w_msg = 2'b11;
      default:    w_msg = 2'b00;
    endcase
    w_ready = (w_state != SHOW_ERR);
    w_busy  = (w_state == SHOW_ERR);
  end

  // State, hold counter, held result and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_sgn   <= 1'b0;
      r_dot   <= '0;
      r_have  <= 1'b0;
      r_ready <= 1'b0;
      r_msg   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bin   <= w_bin;
      r_sgn   <= w_sgn;
      r_dot   <= w_dot;
      r_have  <= w_have;
      r_ready <= w_ready;
      r_msg   <= w_msg;
      r_busy  <= w_busy;
    end
  end

  assign res_ready = r_ready;
  assign msg       = r_msg;
  assign bin       = r_bin;
  assign sgn       = r_sgn;
  assign dot       = r_dot;
  assign busy      = r_busy;

endmodule

// File: tb/tb_disp_msg_seq.sv
// Self-checking bench for disp_msg_seq: directed scenarios with literal
// expectations plus randomized traffic compared against a display model.
module tb_disp_msg_seq;

  localparam int HOLD = 4;
`ifdef DISP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic [1:0]  res_dot;
  logic        op_req;
  logic        val_req;
  logic        res_ready;
  logic [1:0]  msg;
  logic [7:0]  bin;
  logic        sgn;
  logic [1:0]  dot;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model of what the display must show.
  int m_msg   = 0;
  int m_bin   = 0;
  int m_sgn   = 0;
  int m_dot   = 0;
  int m_hold  = 0;
  int m_ready = 0;

  disp_msg_seq #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .res_dot(res_dot), .op_req(op_req), .val_req(val_req),
    .res_ready(res_ready), .msg(msg), .bin(bin), .sgn(sgn), .dot(dot),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int prompt_of(input logic op, input logic val);
    return op ? 1 : (val ? 2 : 0);
  endfunction

  // Display model, advanced on every clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_msg = 0; m_bin = 0; m_sgn = 0; m_dot = 0; m_hold = 0; m_ready = 0;
      end else begin
        if (m_hold > 0) begin
          if (m_hold == 1) begin
            m_msg = prompt_of(op_req, val_req);
            m_bin = 0; m_sgn = 0; m_dot = 0;
          end
          m_hold--;
        end else if (res_valid && m_ready != 0) begin
          int v;
          int mag;
          v   = int'($signed(res_data));
          mag = (v < 0) ? -v : v;
          if (res_err || (mag > 255 && !SAT)) begin
            m_msg  = 3;
            m_hold = HOLD;
          end else begin
            m_msg = 0;
            m_bin = (mag > 255) ? 255 : mag;
            m_sgn = (v < 0) ? 1 : 0;
            m_dot = int'(res_dot);
          end
        end else begin
          m_msg = prompt_of(op_req, val_req);
        end
        m_ready = (m_msg != 3) ? 1 : 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m.msg", int'(msg), m_msg);
      chk("m.ready", int'(res_ready), m_ready);
      chk("m.busy", int'(busy), (m_msg == 3) ? 1 : 0);
      if (m_msg == 0) begin
        chk("m.bin", int'(bin), m_bin);
        chk("m.sgn", int'(sgn), m_sgn);
        chk("m.dot", int'(dot), m_dot);
      end
    end
  end

  task automatic offer(input logic [15:0] d, input logic e, input logic [1:0] dp);
    res_valid = 1'b1; res_data = d; res_err = e; res_dot = dp;
    step(1);
    res_valid = 1'b0; res_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0; res_valid = 1'b0; res_data = '0; res_err = 1'b0;
    res_dot = '0; op_req = 1'b0; val_req = 1'b0;
    step(2);
    chk("rst.msg", int'(msg), 0);
    chk("rst.ready", int'(res_ready), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.bin", int'(bin), 0);
    rst = 1'b1;
    step(1);
    chk("rel.ready", int'(res_ready), 1);

    // Both requests from IDLE, then peel them off.
    op_req = 1'b1; val_req = 1'b1; step(1);
    chk("opval.msg", int'(msg), 1);
    op_req = 1'b0; step(1);
    chk("val.msg", int'(msg), 2);
    val_req = 1'b0; step(1);
    chk("idle.msg", int'(msg), 0);
    chk("idle.bin", int'(bin), 0);

    // Negative result with decimal point.
    offer(16'(-123), 1'b0, 2'd1);
    chk("n123.msg", int'(msg), 0);
    chk("n123.bin", int'(bin), 123);
    chk("n123.sgn", int'(sgn), 1);
    chk("n123.dot", int'(dot), 1);

    // Magnitude overflow.
    offer(16'd300, 1'b0, 2'd0);
    if (SAT) begin
      chk("p300.msg", int'(msg), 0);
      chk("p300.bin", int'(bin), 255);
      chk("p300.sgn", int'(sgn), 0);
    end else begin
      for (int i = 0; i < HOLD; i++) begin
        chk("p300.err", int'(msg), 3);
        chk("p300.busy", int'(busy), 1);
        chk("p300.ready", int'(res_ready), 0);
        if (i < HOLD - 1) step(1);
      end
      step(1);
      chk("p300.after", int'(msg), 0);
      chk("p300.bin0", int'(bin), 0);
      chk("p300.busy0", int'(busy), 0);
    end

    // Most negative value must never look like +0 or wrap.
    offer(16'h8000, 1'b0, 2'd2);
    if (SAT) begin
      chk("min.bin", int'(bin), 255);
      chk("min.sgn", int'(sgn), 1);
    end else begin
      chk("min.err", int'(msg), 3);
      step(HOLD);
      chk("min.after", int'(msg), 0);
    end

    // Zero after a negative value shows no sign.
    offer(16'(-7), 1'b0, 2'd0);
    chk("n7.sgn", int'(sgn), 1);
    offer(16'd0, 1'b0, 2'd0);
    chk("zero.sgn", int'(sgn), 0);
    chk("zero.bin", int'(bin), 0);

    // Result beats op_req on the same edge; prompt follows next edge.
    op_req = 1'b1;
    offer(16'd9, 1'b0, 2'd3);
    chk("pri.msg", int'(msg), 0);
    chk("pri.bin", int'(bin), 9);
    step(1);
    chk("pri.op", int'(msg), 1);
    op_req = 1'b0; step(1);
    chk("pri.back", int'(msg), 0);
    chk("pri.keep", int'(bin), 9);

    // Reset in the middle of an error hold.
    offer(16'd5, 1'b1, 2'd0);
    step(1);
    chk("hold.err", int'(msg), 3);
    #2 rst = 1'b0;
    #1;
    chk("arst.msg", int'(msg), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.ready", int'(res_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    res_valid = 1'b1; res_data = 16'd77;
    step(1);
    chk("arel.ready", int'(res_ready), 1);
    chk("arel.msg", int'(msg), 0);
    chk("arel.bin", int'(bin), 0);
    step(1);
    res_valid = 1'b0;
    chk("arel.take", int'(bin), 77);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 600; n++) begin
      res_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       res_data = 16'($signed($urandom_range(0, 600)) - 300);
        1:       res_data = 16'($urandom);
        2:       res_data = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'd0;
        default: res_data = 16'($signed($urandom_range(0, 520)) - 260);
      endcase
      res_err = ($urandom_range(0, 7) == 0);
      res_dot = 2'($urandom_range(0, 3));
      op_req  = ($urandom_range(0, 3) == 0);
      val_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        step(1);
        rst = 1'b1;
      end
      step(1);
    end
    res_valid = 1'b0; op_req = 1'b0; val_req = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_msg_seq.md
DISP_MSG_SEQ -- requirements
Module: disp_msg_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the number of clk cycles an ERR message is held before the prompt is restored (legal range 1..2^26-1).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port res_valid  input  1  calculator result/error offer.
REQ-005 The block SHALL have port res_data  input  16  signed two's-complement result.
REQ-006 The block SHALL have port res_err  input  1  calculator-detected error (divide by zero etc.), qualified by res_valid.
REQ-007 The block SHALL have port res_dot  input  2  decimal-point digit index for the result, qualified by res_valid.
REQ-008 The block SHALL have port op_req  input  1  level: calculator waits for an operator.
REQ-009 The block SHALL have port val_req  input  1  level: calculator waits for an operand.
REQ-010 The block SHALL have port res_ready  output  1  result accepted when res_valid&res_ready at a clk edge.
REQ-011 The block SHALL have port msg  output  2  display mode: 00 number, 01 "OP", 10 "VAL", 11 "ERR".
REQ-012 The block SHALL have port bin  output  8  unsigned magnitude shown when msg=00.
REQ-013 The block SHALL have port sgn  output  1  1 = show minus sign when msg=00.
REQ-014 The block SHALL have port dot  output  2  decimal-point digit index when msg=00.
REQ-015 The block SHALL have port busy  output  1  high while an ERR hold is in progress.

Function
REQ-016 The block SHALL implement a FSM with states IDLE, PROMPT_OP, PROMPT_VAL, SHOW_RES and SHOW_ERR; all outputs are registered, with one-cycle latency from the triggering input edge.
REQ-017 The block SHALL drive outputs by state as follows: IDLE/SHOW_RES give msg=00 with the held bin/sgn/dot; PROMPT_OP gives msg=01; PROMPT_VAL gives msg=10; SHOW_ERR gives msg=11. In IDLE, bin=0, sgn=0 and dot=0.
REQ-018 The block SHALL hold res_ready=1 in every state except SHOW_ERR, where it is 0.
REQ-019 On an accepted result with res_err=1, the block SHALL enter SHOW_ERR and load the hold counter with HOLD_CYCLES-1.
REQ-020 On an accepted result with res_err=0, the block SHALL compute mag=|res_data| in 17 bits; if mag>255 it SHALL overflow (REQ-031); otherwise it SHALL latch bin=mag[7:0], sgn=res_data[15] and dot=res_dot, then enter SHOW_RES.
REQ-021 The block SHALL treat res_data=-32768 as overflow and SHALL never display it as +0 or as a wrapped value.
REQ-022 The block SHALL latch sgn=0 when res_data=0 (no negative zero).
REQ-023 From IDLE or SHOW_RES, when no result is accepted, op_req=1 SHALL go to PROMPT_OP, else val_req=1 SHALL go to PROMPT_VAL; bin/sgn/dot SHALL be retained while prompting.
REQ-024 In a prompt state, deassertion of the governing request SHALL return to SHOW_RES if a result was ever latched, else to IDLE; op_req=1 SHALL override val_req=1 in every state.
REQ-025 Priority on a single edge SHALL be: accepted result > op_req > val_req.
REQ-026 In SHOW_ERR, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to PROMPT_OP if op_req=1, else PROMPT_VAL if val_req=1, else IDLE, and SHALL clear the held bin/sgn/dot to 0.
REQ-027 The block SHALL hold busy=1 exactly while in SHOW_ERR.

Reset
REQ-028 Asserting rst (low) at any time, including mid-hold, SHALL immediately force IDLE, msg=00, bin=0, sgn=0, dot=0, busy=0, res_ready=0, counter=0, and clear the result-latched flag.
REQ-029 The block SHALL raise res_ready to 1 on the first clk edge after rst deasserts; no result SHALL be accepted on that edge.

Configuration
REQ-030 Macro DISP_SATURATE_EN SHALL select overflow handling.
REQ-031 With DISP_SATURATE_EN defined, overflow SHALL latch bin=255, sgn=res_data[15], dot=res_dot and enter SHOW_RES; without it, overflow SHALL be handled exactly as res_err=1 (SHOW_ERR).

Verification
REQ-032 The bench SHALL check: res_valid, res_data=-123, res_dot=1 -> next cycle msg=00, bin=123, sgn=1, dot=1, state SHOW_RES.
REQ-033 The bench SHALL check: res_data=300, macro undefined -> msg=11, busy=1, res_ready=0 for HOLD_CYCLES cycles (HOLD_CYCLES=4 in sim), then msg=00, bin=0 with op_req=val_req=0; with the macro defined -> bin=255, sgn=0.
REQ-034 The bench SHALL check: res_data=-32768 -> ERR (or bin=255, sgn=1 with DISP_SATURATE_EN); res_data=0 -> sgn=0.
REQ-035 The bench SHALL check: op_req=1 and val_req=1 together from IDLE -> msg=01; drop op_req -> msg=10; drop val_req -> msg=00, bin=0 (IDLE, no result latched).
REQ-036 The bench SHALL check: res_valid=1 with op_req=1 on the same edge -> result shown (msg=00); the next edge -> msg=01.
REQ-037 The bench SHALL check: rst low for 1 cycle during an ERR hold (2 cycles in) -> msg=00, busy=0, res_ready=0 immediately; after release res_ready=1 and no stale ERR.
